// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the request sources and the arbiter.
// The master drives enable/mode/requests; the slave (arbiter) returns the grant.
interface req_arbiter_if;
    logic       enable;
    logic       rr_mode;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output enable, rr_mode, req,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  enable, rr_mode, req,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/req_arbiter.sv
// Eight-way grant controller: highest-index-wins or round-robin arbitration,
// registered one-hot grant held until release or hold timeout.
module req_arbiter #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    req_arbiter_if.slave bus
);
    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_GRANT  = 1'b1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [0:0]        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [2:0]        last_id_q, last_id_d;
    logic [7:0]        mask_q, mask_d;
    logic [7:0]        gnt_q, gnt_d;
    logic [2:0]        gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q, timeout_d;

    logic [7:0] eligible;
    logic [2:0] search_base;
    logic [2:0] cand;
    logic [2:0] winner;
    logic       winner_found;

    assign eligible = bus.req & ~mask_q;

    // Search downward from base-1, wrapping, so base itself is tried last;
    // a base of 0 gives the plain 7..0 fixed-priority order.
    always_comb begin
        winner       = 3'd0;
        winner_found = 1'b0;
        cand         = 3'd0;
        search_base  = bus.rr_mode ? last_id_q : 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = search_base - 3'(k);
            if (!winner_found && eligible[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_id_d   = last_id_q;
        mask_d      = mask_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    mask_d = 8'h00;
                    if (winner_found) begin
                        state_d     = ST_GRANT;
                        cnt_d       = '0;
                        last_id_d   = winner;
                        gnt_d       = 8'd1 << winner;
                        gnt_id_d    = winner;
                        gnt_valid_d = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (!bus.enable || !bus.req[gnt_id_q] || (cnt_q == HOLD_LAST)) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    gnt_d       = 8'h00;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    // Forced release: shut the hog out of the next arbitration only.
                    if (bus.enable && bus.req[gnt_id_q]) begin
                        timeout_d = 1'b1;
                        mask_d    = 8'd1 << gnt_id_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_id_q   <= 3'd0;
            mask_q      <= 8'h00;
            gnt_q       <= 8'h00;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            mask_q      <= mask_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: directed vector table, asynchronous reset sequence,
// then random traffic compared against a behavioural model.
module tb_req_arbiter;
    localparam int HOLD_W   = 4;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;

    req_arbiter_if bus_if ();

    req_arbiter #(
        .HOLD_W   (HOLD_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       rr;
        logic [7:0] req;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic       exp_to;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    // Model state: owner index or -1, edges held since grant, last winner,
    // requester excluded from the next enabled arbitration (-1 for none).
    int m_owner;
    int m_held;
    int m_last;
    int m_excl;
    bit m_to;

    logic [7:0] rnd_req;
    logic       rnd_en;
    logic       rnd_rr;

    function automatic void addVec(logic en, logic rr, logic [7:0] rq,
                                   logic v, logic [2:0] id, logic to);
        vec_t r;
        r.en        = en;
        r.rr        = rr;
        r.req       = rq;
        r.exp_valid = v;
        r.exp_id    = id;
        r.exp_to    = to;
        vecs.push_back(r);
    endfunction

    function automatic void modelReset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 0;
        m_excl  = -1;
        m_to    = 1'b0;
    endfunction

    function automatic void modelStep(logic en, logic rr, logic [7:0] rq);
        int start;
        int win;
        int c;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (en) begin
                start = rr ? m_last : 0;
                win   = -1;
                for (int k = 1; k <= 8; k++) begin
                    c = (start - k + 8) % 8;
                    if (win < 0 && rq[c] && c != m_excl) win = c;
                end
                m_excl = -1;
                if (win >= 0) begin
                    m_owner = win;
                    m_held  = 0;
                    m_last  = win;
                end
            end
        end else if (!en || !rq[m_owner]) begin
            m_owner = -1;
        end else if (m_held + 1 == MAX_HOLD) begin
            m_excl  = m_owner;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endfunction

    task automatic applyStimulus(input logic en, input logic rr, input logic [7:0] rq);
        bus_if.enable  = en;
        bus_if.rr_mode = rr;
        bus_if.req     = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] eid,
                               input logic ev, input logic eto);
        total++;
        if ({bus_if.gnt, bus_if.gnt_id, bus_if.gnt_valid, bus_if.timeout} !== {eg, eid, ev, eto}) begin
            bad++;
            $display("[TB] FAIL %s: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
                     name, bus_if.gnt, bus_if.gnt_id, bus_if.gnt_valid, bus_if.timeout, eg, eid, ev, eto);
        end
    endtask

    initial begin
        logic [7:0] eg;
        int         w;

        // Fixed priority, enable drop, and a grant to 0 so last_id restarts at 0.
        addVec(1, 0, 8'hFF, 1, 7, 0);
        addVec(0, 0, 8'hFF, 0, 0, 0);
        addVec(0, 0, 8'hFF, 0, 0, 0);
        addVec(1, 0, 8'h2C, 1, 5, 0);
        addVec(1, 0, 8'h2C, 1, 5, 0);
        addVec(1, 0, 8'h0C, 0, 0, 0);
        addVec(1, 0, 8'h0C, 1, 3, 0);
        addVec(1, 0, 8'h00, 0, 0, 0);
        addVec(1, 0, 8'h01, 1, 0, 0);
        addVec(1, 0, 8'h00, 0, 0, 0);
        // Round robin, every owner holds two cycles then drops for one.
        for (int i = 0; i < 9; i++) begin
            w = (15 - i) % 8;
            addVec(1, 1, 8'hFF, 1, 3'(w), 0);
            addVec(1, 1, 8'hFF, 1, 3'(w), 0);
            addVec(1, 1, 8'hFF & ~(8'd1 << w), 0, 0, 0);
        end
        // Two requesters timing out in turn.
        addVec(1, 0, 8'h09, 1, 3, 0);
        addVec(1, 0, 8'h09, 1, 3, 0);
        addVec(1, 0, 8'h09, 1, 3, 0);
        addVec(1, 0, 8'h09, 1, 3, 0);
        addVec(1, 0, 8'h09, 0, 0, 1);
        addVec(1, 0, 8'h09, 1, 0, 0);
        addVec(1, 0, 8'h09, 1, 0, 0);
        addVec(1, 0, 8'h09, 1, 0, 0);
        addVec(1, 0, 8'h09, 1, 0, 0);
        addVec(1, 0, 8'h09, 0, 0, 1);
        addVec(1, 0, 8'h09, 1, 3, 0);
        addVec(1, 0, 8'h00, 0, 0, 0);
        // Sole masked requester sits out one arbitration edge.
        addVec(1, 0, 8'h04, 1, 2, 0);
        addVec(1, 0, 8'h04, 1, 2, 0);
        addVec(1, 0, 8'h04, 1, 2, 0);
        addVec(1, 0, 8'h04, 1, 2, 0);
        addVec(1, 0, 8'h04, 0, 0, 1);
        addVec(1, 0, 8'h04, 0, 0, 0);
        addVec(1, 0, 8'h04, 1, 2, 0);
        addVec(1, 0, 8'h00, 0, 0, 0);
        // Enable dropped mid-grant, then a mode change that must not disturb the owner.
        addVec(1, 0, 8'h40, 1, 6, 0);
        addVec(0, 0, 8'h40, 0, 0, 0);
        addVec(0, 0, 8'h40, 0, 0, 0);
        addVec(1, 0, 8'h40, 1, 6, 0);
        addVec(1, 1, 8'h40, 1, 6, 0);

        rst_n          = 1'b0;
        bus_if.enable  = 1'b1;
        bus_if.rr_mode = 1'b0;
        bus_if.req     = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].rr, vecs[i].req);
            eg = vecs[i].exp_valid ? (8'd1 << vecs[i].exp_id) : 8'h00;
            checkOutput($sformatf("vec%0d", i), eg, vecs[i].exp_id, vecs[i].exp_valid, vecs[i].exp_to);
        end

        // Grant 6 is active here; reset must clear it before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        modelReset();
        rnd_req = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            rnd_en = ($urandom_range(0, 9) != 0);
            rnd_rr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                rnd_req = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            applyStimulus(rnd_en, rnd_rr, rnd_req);
            modelStep(rnd_en, rnd_rr, rnd_req);
            eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
            checkOutput($sformatf("rand%0d", n), eg, (m_owner >= 0) ? 3'(m_owner) : 3'd0,
                        (m_owner >= 0), m_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
